// File: rtl/axis_pkt_fifo.sv
// Packet-aware AXI-Stream FIFO with first-word fall-through, occupancy and packet counters.
// Define AXIS_PKT_FIFO_SAF_EN for store-and-forward release; default build is cut-through.
module axis_pkt_fifo #(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic [DW-1:0] s_axis_data,
  input  logic          s_axis_valid,
  input  logic          s_axis_last,
  output logic          s_axis_ready,
  output logic [DW-1:0] m_axis_data,
  output logic          m_axis_valid,
  output logic          m_axis_last,
  input  logic          m_axis_ready,
  output logic [AW:0]   level,
  output logic [AW:0]   pkt_count
);

  localparam logic [AW:0] Full = (AW + 1)'(DEPTH);
  localparam logic [AW:0] One  = (AW + 1)'(1);

  logic [DW:0]   mem [DEPTH];
  logic [DW:0]   head;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic [AW:0]   pkt_count_q, pkt_count_d;
  logic          push, pop, pkt_in, pkt_out;
  logic          head_avail;

  assign head       = mem[rd_ptr_q];
  assign push       = s_axis_valid && s_axis_ready;
  assign pop        = m_axis_valid && m_axis_ready;
  assign pkt_in     = push && s_axis_last;
  assign pkt_out    = pop && m_axis_last;
  assign head_avail = (level_q != '0);

`ifdef AXIS_PKT_FIFO_SAF_EN
  // Once the FIFO fills without a complete packet, keep releasing until that packet's last pops.
  logic flushing_q, flushing_d;

  always_comb begin
    flushing_d = flushing_q;
    if (pkt_out) begin
      flushing_d = 1'b0;
    end else if (level_q == Full && pkt_count_q == '0) begin
      flushing_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      flushing_q <= 1'b0;
    end else begin
      flushing_q <= flushing_d;
    end
  end

  assign m_axis_valid = head_avail &&
                        (pkt_count_q != '0 || level_q == Full || flushing_q);
`else
  assign m_axis_valid = head_avail;
`endif

  assign s_axis_ready = resetn && (level_q != Full);
  assign m_axis_data  = resetn ? head[DW-1:0] : '0;
  assign m_axis_last  = resetn && head[DW];
  assign level        = level_q;
  assign pkt_count    = pkt_count_q;

  always_comb begin
    wr_ptr_d    = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d    = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d     = level_q;
    pkt_count_d = pkt_count_q;
    unique case ({push, pop})
      2'b10:   level_d = level_q + One;
      2'b01:   level_d = level_q - One;
      default: level_d = level_q;
    endcase
    unique case ({pkt_in, pkt_out})
      2'b10:   pkt_count_d = pkt_count_q + One;
      2'b01:   pkt_count_d = pkt_count_q - One;
      default: pkt_count_d = pkt_count_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      pkt_count_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      pkt_count_q <= pkt_count_d;
    end
  end

  // Storage is not reset; the pointers alone define valid contents.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= {s_axis_last, s_axis_data};
    end
  end

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Directed bench for axis_pkt_fifo; store-and-forward scenarios run when
// AXIS_PKT_FIFO_SAF_EN is defined, cut-through scenarios otherwise.
module tb_axis_pkt_fifo;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] s_axis_data = '0;
  logic       s_axis_valid = 1'b0;
  logic       s_axis_last = 1'b0;
  logic       s_axis_ready;
  logic [7:0] m_axis_data;
  logic       m_axis_valid;
  logic       m_axis_last;
  logic       m_axis_ready = 1'b0;
  logic [4:0] level;
  logic [4:0] pkt_count;

  int checks = 0;
  int errors = 0;

  axis_pkt_fifo dut (
    .clk          (clk),
    .resetn       (resetn),
    .s_axis_data  (s_axis_data),
    .s_axis_valid (s_axis_valid),
    .s_axis_last  (s_axis_last),
    .s_axis_ready (s_axis_ready),
    .m_axis_data  (m_axis_data),
    .m_axis_valid (m_axis_valid),
    .m_axis_last  (m_axis_last),
    .m_axis_ready (m_axis_ready),
    .level        (level),
    .pkt_count    (pkt_count)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    repeat (3) tick();
    checks++;
    if (s_axis_ready !== 1'b0 || m_axis_valid !== 1'b0 || m_axis_data !== 8'h00 ||
        m_axis_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b data=%h last=%b, want 0 0 00 0",
               s_axis_ready, m_axis_valid, m_axis_data, m_axis_last);
    end
    checks++;
    if (level !== 5'd0 || pkt_count !== 5'd0) begin
      errors++;
      $display("FAIL reset_counts: got level=%0d pkt=%0d, want 0 0", level, pkt_count);
    end
    resetn = 1'b1;
    #1;
    checks++;
    if (s_axis_ready !== 1'b1 || level !== 5'd0) begin
      errors++;
      $display("FAIL reset_release: got rdy=%b level=%0d, want 1 0", s_axis_ready, level);
    end
  endtask

  task automatic test_basic;
    logic [7:0] vec [3];
    vec[0] = 8'h11; vec[1] = 8'h22; vec[2] = 8'h33;
    m_axis_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_axis_valid = 1'b1; s_axis_data = vec[i]; s_axis_last = (i == 2);
      tick();
    end
    s_axis_valid = 1'b0; s_axis_last = 1'b0;
    checks++;
    if (level !== 5'd3 || pkt_count !== 5'd1 || m_axis_data !== 8'h11 || m_axis_valid !== 1'b1) begin
      errors++;
      $display("FAIL basic_fill: got level=%0d pkt=%0d data=%h vld=%b, want 3 1 11 1",
               level, pkt_count, m_axis_data, m_axis_valid);
    end
    m_axis_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (m_axis_valid !== 1'b1 || m_axis_data !== vec[i] || m_axis_last !== (i == 2)) begin
        errors++;
        $display("FAIL basic_drain[%0d]: got vld=%b data=%h last=%b, want 1 %h %b",
                 i, m_axis_valid, m_axis_data, m_axis_last, vec[i], (i == 2));
      end
      tick();
    end
    m_axis_ready = 1'b0;
    checks++;
    if (level !== 5'd0 || pkt_count !== 5'd0 || m_axis_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_empty: got level=%0d pkt=%0d vld=%b, want 0 0 0",
               level, pkt_count, m_axis_valid);
    end
  endtask

  task automatic test_full_wrap;
    m_axis_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      s_axis_valid = 1'b1; s_axis_data = 8'(i); s_axis_last = (i % 4 == 3);
      tick();
    end
    s_axis_data = 8'h10; s_axis_last = 1'b1;
    checks++;
    if (s_axis_ready !== 1'b0 || level !== 5'd16 || pkt_count !== 5'd4) begin
      errors++;
      $display("FAIL full: got rdy=%b level=%0d pkt=%0d, want 0 16 4",
               s_axis_ready, level, pkt_count);
    end
    m_axis_ready = 1'b1;
    tick();
    m_axis_ready = 1'b0;
    checks++;
    if (s_axis_ready !== 1'b1 || level !== 5'd15 || m_axis_data !== 8'h01) begin
      errors++;
      $display("FAIL full_pop: got rdy=%b level=%0d data=%h, want 1 15 01",
               s_axis_ready, level, m_axis_data);
    end
    tick();
    s_axis_valid = 1'b0; s_axis_last = 1'b0;
    checks++;
    if (level !== 5'd16 || pkt_count !== 5'd5) begin
      errors++;
      $display("FAIL wrap_push: got level=%0d pkt=%0d, want 16 5", level, pkt_count);
    end
    m_axis_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      checks++;
      if (m_axis_valid !== 1'b1 || m_axis_data !== 8'(i) ||
          m_axis_last !== (i % 4 == 3 || i == 16)) begin
        errors++;
        $display("FAIL wrap_order[%0d]: got vld=%b data=%h last=%b, want 1 %h %b",
                 i, m_axis_valid, m_axis_data, m_axis_last, 8'(i), (i % 4 == 3 || i == 16));
      end
      tick();
    end
    m_axis_ready = 1'b0;
    checks++;
    if (level !== 5'd0 || pkt_count !== 5'd0) begin
      errors++;
      $display("FAIL wrap_empty: got level=%0d pkt=%0d, want 0 0", level, pkt_count);
    end
  endtask

  task automatic test_back_to_back;
    m_axis_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      s_axis_valid = 1'b1; s_axis_data = 8'(8'h40 + i); s_axis_last = (i % 8 == 7);
      if (i > 0) begin
        checks++;
        if (m_axis_valid !== 1'b1 || m_axis_data !== 8'(8'h40 + i - 1) || level !== 5'd1 ||
            s_axis_ready !== 1'b1) begin
          errors++;
          $display("FAIL b2b[%0d]: got vld=%b data=%h level=%0d rdy=%b, want 1 %h 1 1",
                   i, m_axis_valid, m_axis_data, level, s_axis_ready, 8'(8'h40 + i - 1));
        end
      end
      tick();
    end
    s_axis_valid = 1'b0; s_axis_last = 1'b0;
    checks++;
    if (m_axis_data !== 8'h67 || m_axis_last !== 1'b1 || level !== 5'd1) begin
      errors++;
      $display("FAIL b2b_tail: got data=%h last=%b level=%0d, want 67 1 1",
               m_axis_data, m_axis_last, level);
    end
    tick();
    m_axis_ready = 1'b0;
    checks++;
    if (level !== 5'd0 || pkt_count !== 5'd0) begin
      errors++;
      $display("FAIL b2b_empty: got level=%0d pkt=%0d, want 0 0", level, pkt_count);
    end
  endtask

  task automatic test_random;
    logic [8:0] q [$];
    logic [7:0] nd;
    int pushed, pkts, rem, cyc;
    logic mpush, mpop;
    nd = 8'h00; pushed = 0; pkts = 0; cyc = 0;
    rem = $urandom_range(5, 1);
    while ((pushed < 200 || q.size() != 0) && cyc < 3000) begin
      s_axis_valid = (pushed < 200) && ($urandom_range(1, 0) == 1);
      s_axis_data  = nd;
      s_axis_last  = (rem == 1);
      m_axis_ready = ($urandom_range(1, 0) == 1);
      checks++;
      if (level !== 5'(q.size()) || pkt_count !== 5'(pkts) ||
          m_axis_valid !== (q.size() != 0) || s_axis_ready !== (q.size() != 16)) begin
        errors++;
        $display("FAIL rand_state cyc %0d: got level=%0d pkt=%0d vld=%b rdy=%b, want %0d %0d %b %b",
                 cyc, level, pkt_count, m_axis_valid, s_axis_ready, q.size(), pkts,
                 (q.size() != 0), (q.size() != 16));
      end
      if (q.size() != 0) begin
        checks++;
        if ({m_axis_last, m_axis_data} !== q[0]) begin
          errors++;
          $display("FAIL rand_data cyc %0d: got last=%b data=%h, want %b %h",
                   cyc, m_axis_last, m_axis_data, q[0][8], q[0][7:0]);
        end
      end
      mpush = s_axis_valid && (q.size() != 16);
      mpop  = m_axis_ready && (q.size() != 0);
      tick();
      if (mpop) begin
        if (q[0][8]) pkts--;
        void'(q.pop_front());
      end
      if (mpush) begin
        q.push_back({s_axis_last, s_axis_data});
        if (s_axis_last) pkts++;
        pushed++;
        nd = nd + 8'd1;
        rem--;
        if (rem == 0) rem = $urandom_range(5, 1);
      end
      cyc++;
    end
    s_axis_valid = 1'b0; s_axis_last = 1'b0; m_axis_ready = 1'b0;
    checks++;
    if (cyc >= 3000) begin
      errors++;
      $display("FAIL rand_timeout: got %0d pushed %0d queued, want 200 0", pushed, q.size());
    end
  endtask

  task automatic test_reset_mid_packet;
    m_axis_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      s_axis_valid = 1'b1; s_axis_data = 8'(8'h50 + i); s_axis_last = (i == 1);
      tick();
    end
    s_axis_valid = 1'b0; s_axis_last = 1'b0;
    checks++;
    if (level !== 5'd5 || pkt_count !== 5'd1) begin
      errors++;
      $display("FAIL pre_reset: got level=%0d pkt=%0d, want 5 1", level, pkt_count);
    end
    resetn = 1'b0;
    #1;
    checks++;
    if (m_axis_valid !== 1'b0 || level !== 5'd0 || pkt_count !== 5'd0 || s_axis_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got vld=%b level=%0d pkt=%0d rdy=%b, want 0 0 0 0",
               m_axis_valid, level, pkt_count, s_axis_ready);
    end
    tick();
    resetn = 1'b1;
    #1;
    checks++;
    if (s_axis_ready !== 1'b1 || level !== 5'd0) begin
      errors++;
      $display("FAIL post_reset: got rdy=%b level=%0d, want 1 0", s_axis_ready, level);
    end
    s_axis_valid = 1'b1; s_axis_data = 8'hA1; s_axis_last = 1'b0;
    tick();
    s_axis_data = 8'hA2; s_axis_last = 1'b1;
    tick();
    s_axis_valid = 1'b0; s_axis_last = 1'b0;
    checks++;
    if (level !== 5'd2 || pkt_count !== 5'd1 || m_axis_data !== 8'hA1 || m_axis_valid !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_pkt: got level=%0d pkt=%0d data=%h vld=%b, want 2 1 a1 1",
               level, pkt_count, m_axis_data, m_axis_valid);
    end
    m_axis_ready = 1'b1;
    tick();
    checks++;
    if (m_axis_data !== 8'hA2 || m_axis_last !== 1'b1 || m_axis_valid !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_tail: got data=%h last=%b vld=%b, want a2 1 1",
               m_axis_data, m_axis_last, m_axis_valid);
    end
    tick();
    m_axis_ready = 1'b0;
    checks++;
    if (level !== 5'd0 || pkt_count !== 5'd0) begin
      errors++;
      $display("FAIL post_reset_empty: got level=%0d pkt=%0d, want 0 0", level, pkt_count);
    end
  endtask

`ifdef AXIS_PKT_FIFO_SAF_EN
  task automatic test_saf_hold;
    m_axis_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_axis_valid = 1'b1; s_axis_data = 8'(8'h60 + i); s_axis_last = (i == 3);
      tick();
      checks++;
      if (m_axis_valid !== (i == 3)) begin
        errors++;
        $display("FAIL saf_hold[%0d]: got vld=%b, want %b", i, m_axis_valid, (i == 3));
      end
    end
    s_axis_valid = 1'b0; s_axis_last = 1'b0;
    m_axis_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (m_axis_valid !== 1'b1 || m_axis_data !== 8'(8'h60 + i)) begin
        errors++;
        $display("FAIL saf_drain[%0d]: got vld=%b data=%h, want 1 %h",
                 i, m_axis_valid, m_axis_data, 8'(8'h60 + i));
      end
      tick();
    end
    m_axis_ready = 1'b0;
  endtask

  task automatic test_saf_flush;
    int pushed, popped, cyc, lvl;
    logic mpush, mpop;
    m_axis_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      s_axis_valid = 1'b1; s_axis_data = 8'(8'h80 + i); s_axis_last = 1'b0;
      tick();
    end
    checks++;
    if (level !== 5'd16 || pkt_count !== 5'd0 || m_axis_valid !== 1'b1) begin
      errors++;
      $display("FAIL saf_full: got level=%0d pkt=%0d vld=%b, want 16 0 1",
               level, pkt_count, m_axis_valid);
    end
    pushed = 16; popped = 0; cyc = 0;
    m_axis_ready = 1'b1;
    while (popped < 20 && cyc < 200) begin
      lvl = pushed - popped;
      s_axis_valid = (pushed < 20);
      s_axis_data  = 8'(8'h80 + pushed);
      s_axis_last  = (pushed == 19);
      checks++;
      if (m_axis_valid !== (lvl != 0) || (lvl != 0 && m_axis_data !== 8'(8'h80 + popped)) ||
          (lvl != 0 && m_axis_last !== (popped == 19))) begin
        errors++;
        $display("FAIL saf_flush[%0d]: got vld=%b data=%h last=%b, want %b %h %b",
                 popped, m_axis_valid, m_axis_data, m_axis_last, (lvl != 0),
                 8'(8'h80 + popped), (popped == 19));
      end
      mpush = s_axis_valid && (lvl != 16);
      mpop  = (lvl != 0);
      tick();
      if (mpush) pushed++;
      if (mpop) popped++;
      cyc++;
    end
    s_axis_valid = 1'b0; s_axis_last = 1'b0; m_axis_ready = 1'b0;
    checks++;
    if (cyc >= 200 || level !== 5'd0 || pkt_count !== 5'd0) begin
      errors++;
      $display("FAIL saf_flush_end: got popped=%0d level=%0d pkt=%0d, want 20 0 0",
               popped, level, pkt_count);
    end
    // Release must close again: a fresh partial packet is held.
    s_axis_valid = 1'b1; s_axis_data = 8'hC1; s_axis_last = 1'b0;
    tick();
    s_axis_valid = 1'b0;
    checks++;
    if (m_axis_valid !== 1'b0 || level !== 5'd1) begin
      errors++;
      $display("FAIL saf_reclose: got vld=%b level=%0d, want 0 1", m_axis_valid, level);
    end
    s_axis_valid = 1'b1; s_axis_data = 8'hC2; s_axis_last = 1'b1;
    tick();
    s_axis_valid = 1'b0; s_axis_last = 1'b0;
    checks++;
    if (m_axis_valid !== 1'b1 || m_axis_data !== 8'hC1) begin
      errors++;
      $display("FAIL saf_release: got vld=%b data=%h, want 1 c1", m_axis_valid, m_axis_data);
    end
    m_axis_ready = 1'b1;
    repeat (2) tick();
    m_axis_ready = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
`ifdef AXIS_PKT_FIFO_SAF_EN
    test_saf_hold();
    test_saf_flush();
`else
    test_full_wrap();
    test_back_to_back();
    test_random();
`endif
    test_reset_mid_packet();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_pkt_fifo.md
# axis_pkt_fifo

Packet-aware AXI-Stream FIFO placed directly downstream of the 2:1 AXI-Stream mux: it absorbs the mux's registered `m_axis_*` output and re-presents it to the consumer with full backpressure decoupling. It tracks occupancy and completed packets so later stages can see packet boundaries, and can optionally hold data until a whole packet is stored.

## Interface
- `DW`, default 8: data width, matching the mux.
- `DEPTH`, default 16: entries; must be a power of 2 and at least 4.
- `AW`, default 4: `log2(DEPTH)`.

Ports:
- `clk`, in, 1: clock; every register is rising-edge.
- `resetn`, in, 1: reset, asynchronous, active-low.
- `s_axis_data`, in, DW: input beat, from the mux `m_axis_data`.
- `s_axis_valid`, in, 1: input valid.
- `s_axis_last`, in, 1: end of packet.
- `s_axis_ready`, out, 1: FIFO can accept a beat.
- `m_axis_data`, out, DW: head-of-FIFO data.
- `m_axis_valid`, out, 1: head beat available.
- `m_axis_last`, out, 1: head beat is the last beat of its packet.
- `m_axis_ready`, in, 1: consumer accepts.
- `level`, out, AW+1: entries currently stored, 0..DEPTH.
- `pkt_count`, out, AW+1: complete packets (last beat stored) not yet fully popped.

## Operation
- Storage:
  - `DEPTH` x (`DW`+1) array holding data and last.
  - `wr_ptr` and `rd_ptr` are AW bits and wrap modulo DEPTH.
  - `level` is a separate counter.
- Push: occurs when `s_axis_valid && s_axis_ready`. Writes `{last, data}` at `wr_ptr`, then `wr_ptr++`.
- Pop: occurs when `m_axis_valid && m_axis_ready`. Then `rd_ptr++`.
- `level`: +1 on push only, -1 on pop only, unchanged when both occur in the same cycle.
- `pkt_count`: +1 on a push with `s_axis_last`=1, -1 on a pop with `m_axis_last`=1, unchanged when both occur.
- `s_axis_ready` = (`level` != DEPTH). It is combinational from registered state and never depends on `s_axis_valid`.
- `m_axis_data` and `m_axis_last` read combinationally from `mem[rd_ptr]` (first-word fall-through).
- `m_axis_valid` = (`level` != 0), subject to the Configuration section.
- Full with a simultaneous pop: `s_axis_ready`=0, so no push occurs; after the pop, `level` = DEPTH-1.
- Empty: `m_axis_valid`=0, and `m_axis_data`/`m_axis_last` are don't-care; the bench must not check them.
- AXI-Stream rule: once `m_axis_valid`=1, it stays 1 and data/last stay stable until a pop.
- Reset, asynchronous, also mid-packet:
  - `wr_ptr`, `rd_ptr`, `level` and `pkt_count` go to 0.
  - `s_axis_ready`=0 while `resetn`=0; `m_axis_valid`=0.
  - All outputs are driven to 0, never Z.
  - Stored and partial packets are discarded; memory contents are not cleared.

## Timing
- Latency: a beat pushed at edge N appears on `m_axis_*` with `m_axis_valid`=1 in the cycle after edge N.
- A pop at edge N exposes the next entry in the cycle after edge N.
- Throughput: one beat per cycle sustained in and out simultaneously at any `level`, including 0 after the first beat and DEPTH-1.
- `s_axis_ready` rises in the cycle after the pop that leaves the FIFO non-full.
- First cycle after `resetn` deasserts: `s_axis_ready`=1, `level`=0.
- `level` and `pkt_count` are registered and reflect all pushes and pops up to the last edge.

## Configuration
- Macro: `AXIS_PKT_FIFO_SAF_EN`.
- Undefined (cut-through): `m_axis_valid` = (`level` != 0).
- Defined (store-and-forward): `m_axis_valid` = (`level` != 0) && (`pkt_count` != 0 || `level` == DEPTH).
  - Beats are held until their packet's last beat is stored.
  - Exception: if the FIFO fills with no complete packet, output is released beat by beat to avoid deadlock.
  - After that exception the release stays open until the current packet's last beat is popped. This is tracked by a `flushing` register: set when `level`==DEPTH && `pkt_count`==0; cleared on a pop with last; reset to 0.
  - `m_axis_valid` is also asserted while `flushing`=1 && `level`!=0.
- Interface, `level` and `pkt_count` are identical in both builds.

## Test plan
- Reset, then push 3 beats (0x11, 0x22, 0x33 with last=1) with `m_axis_ready`=0 -> `level`=3, `pkt_count`=1, `m_axis_data`=0x11. Set ready=1 -> 0x11, 0x22, 0x33 on consecutive cycles, last only on 0x33, then `level`=0.
- Push 16 beats with ready=0 -> `s_axis_ready`=0 at `level`=16. Hold valid, pulse ready for 1 cycle -> 0x00 popped, `s_axis_ready`=1 the next cycle, 17th beat accepted, wrap order preserved.
- Continuous valid=1 and ready=1 for 40 beats with an incrementing pattern -> output identical, no bubbles after the first, `level` steady at 1.
- Random valid/ready (50%), 200 beats, packet lengths 1-5 -> in-order data and last match a scoreboard, `pkt_count` matches the model every cycle.
- Assert `resetn`=0 mid-packet at `level`=5 -> in the same cycle `m_axis_valid`=0, `level`=0, `pkt_count`=0. After release, a new 2-beat packet passes cleanly.
- `AXIS_PKT_FIFO_SAF_EN` defined:
  - 4-beat packet -> `m_axis_valid`=0 until the cycle after the last beat is pushed.
  - 20-beat packet with ready=0 -> `level`=16 and `m_axis_valid`=1; with ready=1 all 20 beats drain in order and `flushing` clears after the last.
